// File: rtl/sprite_motion_engine.sv
// ============================================================================
// Module      : sprite_motion_engine
// Description : Per-frame sprite motion with per-sprite clamping, plus a
//               registered hit test of the current pixel against every sprite.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_motion_engine #(
    parameter int NUM_OBJ = 2,
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int HALF_W  = 25,
    parameter int HALF_H  = 33,
    parameter int STEP    = 1,
    parameter logic [NUM_OBJ*XW-1:0] X_INIT = {10'd560, 10'd80},
    parameter logic [NUM_OBJ*YW-1:0] Y_INIT = {9'd240, 9'd240},
    parameter logic [NUM_OBJ*XW-1:0] X_MIN  = {10'd370, 10'd26},
    parameter logic [NUM_OBJ*XW-1:0] X_MAX  = {10'd614, 10'd270},
    parameter logic [NUM_OBJ*YW-1:0] Y_MIN  = {9'd34, 9'd34},
    parameter logic [NUM_OBJ*YW-1:0] Y_MAX  = {9'd446, 9'd446}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  screen_end,
    input  logic [NUM_OBJ-1:0]    btn_up,
    input  logic [NUM_OBJ-1:0]    btn_down,
    input  logic [NUM_OBJ-1:0]    btn_left,
    input  logic [NUM_OBJ-1:0]    btn_right,
    input  logic [NUM_OBJ-1:0]    boost,
    input  logic [NUM_OBJ-1:0]    hold,
    input  logic                  recentre,
    input  logic [XW-1:0]         x,
    input  logic [YW-1:0]         y,
    output logic [NUM_OBJ*XW-1:0] obj_x,
    output logic [NUM_OBJ*YW-1:0] obj_y,
    output logic                  frame_tick,
    output logic [15:0]           frame_cnt,
    output logic [NUM_OBJ-1:0]    hit,
    output logic                  hit_any,
    output logic [2:0]            hit_id
);

    localparam logic signed [XW+1:0] c_xStep1 = (XW+2)'(STEP);
    localparam logic signed [XW+1:0] c_xStep2 = (XW+2)'(2 * STEP);
    localparam logic signed [YW+1:0] c_yStep1 = (YW+2)'(STEP);
    localparam logic signed [YW+1:0] c_yStep2 = (YW+2)'(2 * STEP);
    localparam logic [XW-1:0]        c_halfW  = XW'(HALF_W);
    localparam logic [YW-1:0]        c_halfH  = YW'(HALF_H);

    logic               r_screenEndQ;
    logic [15:0]        r_frameCnt;
    logic [NUM_OBJ-1:0] r_hit;
    logic               r_hitAny;
    logic [2:0]         r_hitId;
    logic [NUM_OBJ-1:0] w_hitNow;
    logic [2:0]         w_hitId;
    logic               w_tick;

    assign w_tick = screen_end & ~r_screenEndQ;

    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
        localparam logic [XW-1:0] c_xInit = X_INIT[gi*XW +: XW];
        localparam logic [YW-1:0] c_yInit = Y_INIT[gi*YW +: YW];
        localparam logic [XW-1:0] c_xMin  = X_MIN[gi*XW +: XW];
        localparam logic [XW-1:0] c_xMax  = X_MAX[gi*XW +: XW];
        localparam logic [YW-1:0] c_yMin  = Y_MIN[gi*YW +: YW];
        localparam logic [YW-1:0] c_yMax  = Y_MAX[gi*YW +: YW];

        logic [XW-1:0]        r_x;
        logic [YW-1:0]        r_y;
        logic signed [XW+1:0] w_dx;
        logic signed [XW+1:0] w_xCand;
        logic [XW-1:0]        w_xNext;
        logic signed [YW+1:0] w_dy;
        logic signed [YW+1:0] w_yCand;
        logic [YW-1:0]        w_yNext;
        logic [XW-1:0]        w_absDx;
        logic [YW-1:0]        w_absDy;

        // Candidate is two bits wider and signed so under/overshoot saturates instead of wrapping
        always_comb begin
            w_dx = '0;
            if (btn_right[gi] && !btn_left[gi])
                w_dx = boost[gi] ? c_xStep2 : c_xStep1;
            else if (btn_left[gi] && !btn_right[gi])
                w_dx = boost[gi] ? -c_xStep2 : -c_xStep1;
            w_xCand = $signed({2'b00, r_x}) + w_dx;
            if (w_xCand < $signed({2'b00, c_xMin}))
                w_xNext = c_xMin;
            else if (w_xCand > $signed({2'b00, c_xMax}))
                w_xNext = c_xMax;
            else
                w_xNext = w_xCand[XW-1:0];
        end

        always_comb begin
            w_dy = '0;
            if (btn_down[gi] && !btn_up[gi])
                w_dy = boost[gi] ? c_yStep2 : c_yStep1;
            else if (btn_up[gi] && !btn_down[gi])
                w_dy = boost[gi] ? -c_yStep2 : -c_yStep1;
            w_yCand = $signed({2'b00, r_y}) + w_dy;
            if (w_yCand < $signed({2'b00, c_yMin}))
                w_yNext = c_yMin;
            else if (w_yCand > $signed({2'b00, c_yMax}))
                w_yNext = c_yMax;
            else
                w_yNext = w_yCand[YW-1:0];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_x <= c_xInit;
                r_y <= c_yInit;
            end else if (recentre) begin
                r_x <= c_xInit;
                r_y <= c_yInit;
            end else if (w_tick && !hold[gi]) begin
                r_x <= w_xNext;
                r_y <= w_yNext;
            end
        end

        // Subtract the smaller from the larger so the distance never underflows
        assign w_absDx = (x >= r_x) ? (x - r_x) : (r_x - x);
        assign w_absDy = (y >= r_y) ? (y - r_y) : (r_y - y);
        assign w_hitNow[gi] = (w_absDx < c_halfW) && (w_absDy < c_halfH);

        assign obj_x[gi*XW +: XW] = r_x;
        assign obj_y[gi*YW +: YW] = r_y;
    end

    always_comb begin
        w_hitId = '0;
        for (int k = NUM_OBJ - 1; k >= 0; k--) begin
            if (w_hitNow[k])
                w_hitId = 3'(k);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_screenEndQ <= 1'b0;
            r_frameCnt   <= '0;
            r_hit        <= '0;
            r_hitAny     <= 1'b0;
            r_hitId      <= '0;
        end else begin
            r_screenEndQ <= screen_end;
            if (w_tick)
                r_frameCnt <= r_frameCnt + 16'd1;
            r_hit    <= w_hitNow;
            r_hitAny <= |w_hitNow;
            r_hitId  <= w_hitId;
        end
    end

    assign frame_tick = w_tick;
    assign frame_cnt  = r_frameCnt;
    assign hit        = r_hit;
    assign hit_any    = r_hitAny;
    assign hit_id     = r_hitId;

endmodule

`default_nettype wire

// File: tb/tb_sprite_motion_engine.sv
// ============================================================================
// Module      : tb_sprite_motion_engine
// Description : Directed self-checking bench for sprite_motion_engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_motion_engine;

    logic        clk;
    logic        reset;
    logic        screen_end;
    logic [1:0]  btn_up, btn_down, btn_left, btn_right, boost, hold;
    logic        recentre;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [19:0] obj_x;
    logic [17:0] obj_y;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic [1:0]  hit;
    logic        hit_any;
    logic [2:0]  hit_id;

    int testsRun;
    int testsFailed;
    int expFrames;

    sprite_motion_engine dut (
        .clk        (clk),
        .reset      (reset),
        .screen_end (screen_end),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .boost      (boost),
        .hold       (hold),
        .recentre   (recentre),
        .x          (x),
        .y          (y),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt),
        .hit        (hit),
        .hit_any    (hit_any),
        .hit_id     (hit_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One screen_end pulse spanning a single rising clock edge
    task automatic pulse_frame();
        @(negedge clk);
        screen_end = 1'b1;
        @(negedge clk);
        screen_end = 1'b0;
        expFrames++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        testsRun++;
        if (obj_x !== {10'd560, 10'd80} || obj_y !== {9'd240, 9'd240}) begin
            $display("FAIL reset_pos: obj_x=%h obj_y=%h required %h %h", obj_x, obj_y,
                     {10'd560, 10'd80}, {9'd240, 9'd240});
            testsFailed++;
        end
        testsRun++;
        if (hit !== 2'b00 || hit_any !== 1'b0 || hit_id !== 3'd0 || frame_cnt !== 16'd0) begin
            $display("FAIL reset_out: hit=%b any=%b id=%0d cnt=%0d required 0", hit, hit_any,
                     hit_id, frame_cnt);
            testsFailed++;
        end
        @(negedge clk);
        reset = 1'b0;
        expFrames = 0;
    endtask

    task automatic test_move_right();
        btn_right = 2'b01;
        repeat (3) pulse_frame();
        btn_right = 2'b00;
        testsRun++;
        if (obj_x[9:0] !== 10'd83 || obj_x[19:10] !== 10'd560) begin
            $display("FAIL move_right: x0=%0d x1=%0d required 83 560", obj_x[9:0], obj_x[19:10]);
            testsFailed++;
        end
        testsRun++;
        if (frame_cnt !== 16'd3 || obj_y !== {9'd240, 9'd240}) begin
            $display("FAIL move_cnt: cnt=%0d obj_y=%h required 3 %h", frame_cnt, obj_y,
                     {9'd240, 9'd240});
            testsFailed++;
        end
    endtask

    task automatic test_saturate();
        btn_right = 2'b01;
        pulse_frame();
        boost = 2'b01;
        repeat (92) pulse_frame();
        testsRun++;
        if (obj_x[9:0] !== 10'd268) begin
            $display("FAIL sat_setup: x0=%0d required 268", obj_x[9:0]);
            testsFailed++;
        end
        pulse_frame();
        testsRun++;
        if (obj_x[9:0] !== 10'd270) begin
            $display("FAIL sat_first: x0=%0d required 270", obj_x[9:0]);
            testsFailed++;
        end
        pulse_frame();
        testsRun++;
        if (obj_x[9:0] !== 10'd270) begin
            $display("FAIL sat_second: x0=%0d required 270", obj_x[9:0]);
            testsFailed++;
        end
        btn_right = 2'b00;
        boost = 2'b00;
        testsRun++;
        if (frame_cnt !== 16'(expFrames)) begin
            $display("FAIL sat_cnt: cnt=%0d required %0d", frame_cnt, expFrames);
            testsFailed++;
        end
    endtask

    task automatic test_both_lr();
        btn_left = 2'b10;
        btn_right = 2'b10;
        btn_up = 2'b10;
        pulse_frame();
        btn_left = 2'b00;
        btn_right = 2'b00;
        btn_up = 2'b00;
        testsRun++;
        if (obj_x[19:10] !== 10'd560 || obj_y[17:9] !== 9'd239 || obj_x[9:0] !== 10'd270) begin
            $display("FAIL both_lr: x1=%0d y1=%0d x0=%0d required 560 239 270", obj_x[19:10],
                     obj_y[17:9], obj_x[9:0]);
            testsFailed++;
        end
    endtask

    task automatic test_hold();
        hold = 2'b01;
        btn_left = 2'b11;
        pulse_frame();
        hold = 2'b00;
        btn_left = 2'b00;
        testsRun++;
        if (obj_x[9:0] !== 10'd270 || obj_x[19:10] !== 10'd559) begin
            $display("FAIL hold: x0=%0d x1=%0d required 270 559", obj_x[9:0], obj_x[19:10]);
            testsFailed++;
        end
    endtask

    task automatic test_recentre();
        @(negedge clk);
        btn_right = 2'b11;
        btn_down = 2'b11;
        recentre = 1'b1;
        screen_end = 1'b1;
        expFrames++;
        @(negedge clk);
        recentre = 1'b0;
        screen_end = 1'b0;
        btn_right = 2'b00;
        btn_down = 2'b00;
        testsRun++;
        if (obj_x !== {10'd560, 10'd80} || obj_y !== {9'd240, 9'd240}) begin
            $display("FAIL recentre_pos: obj_x=%h obj_y=%h required %h %h", obj_x, obj_y,
                     {10'd560, 10'd80}, {9'd240, 9'd240});
            testsFailed++;
        end
        testsRun++;
        if (frame_cnt !== 16'(expFrames)) begin
            $display("FAIL recentre_cnt: cnt=%0d required %0d", frame_cnt, expFrames);
            testsFailed++;
        end
    endtask

    task automatic test_hit();
        logic [9:0] xv [6]  = '{10'd106, 10'd104, 10'd105, 10'd56, 10'd80, 10'd560};
        logic [8:0] yv [6]  = '{9'd240, 9'd240, 9'd240, 9'd240, 9'd207, 9'd240};
        logic [1:0] hv [6]  = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
        logic [2:0] idv [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            x = xv[i];
            y = yv[i];
            if (i == 1) begin
                #1;
                testsRun++;
                if (hit !== 2'b00) begin
                    $display("FAIL hit_latency: hit=%b required 00 before edge", hit);
                    testsFailed++;
                end
            end
            @(negedge clk);
            testsRun++;
            if (hit !== hv[i] || hit_any !== (|hv[i]) || hit_id !== idv[i]) begin
                $display("FAIL hit_%0d: hit=%b any=%b id=%0d required %b %b %0d", i, hit,
                         hit_any, hit_id, hv[i], |hv[i], idv[i]);
                testsFailed++;
            end
        end
        x = 10'd0;
        y = 9'd0;
    endtask

    task automatic test_reset_mid();
        btn_right = 2'b01;
        pulse_frame();
        btn_right = 2'b00;
        testsRun++;
        if (obj_x[9:0] !== 10'd81) begin
            $display("FAIL premove: x0=%0d required 81", obj_x[9:0]);
            testsFailed++;
        end
        #2;
        reset = 1'b1;
        #1;
        testsRun++;
        if (obj_x !== {10'd560, 10'd80} || frame_cnt !== 16'd0) begin
            $display("FAIL async_reset: obj_x=%h cnt=%0d required %h 0", obj_x, frame_cnt,
                     {10'd560, 10'd80});
            testsFailed++;
        end
        // screen_end already high when reset releases: the first edge must tick
        screen_end = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        testsRun++;
        if (frame_cnt !== 16'd1) begin
            $display("FAIL tick_from_reset: cnt=%0d required 1", frame_cnt);
            testsFailed++;
        end
        screen_end = 1'b0;
    endtask

    task automatic test_long_screen_end();
        int ticks;
        ticks = 0;
        @(negedge clk);
        screen_end = 1'b1;
        #1;
        if (frame_tick === 1'b1) ticks++;
        repeat (49) begin
            @(negedge clk);
            #1;
            if (frame_tick === 1'b1) ticks++;
        end
        @(negedge clk);
        screen_end = 1'b0;
        testsRun++;
        if (ticks != 1 || frame_cnt !== 16'd2) begin
            $display("FAIL long_screen_end: ticks=%0d cnt=%0d required 1 2", ticks, frame_cnt);
            testsFailed++;
        end
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        expFrames = 0;
        screen_end = 1'b0;
        btn_up = '0;
        btn_down = '0;
        btn_left = '0;
        btn_right = '0;
        boost = '0;
        hold = '0;
        recentre = 1'b0;
        x = 10'd0;
        y = 9'd0;
        test_reset();
        test_move_right();
        test_saturate();
        test_both_lr();
        test_hold();
        test_recentre();
        test_hit();
        test_reset_mid();
        test_long_screen_end();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

`default_nettype wire
